alu_md_controller: RTL

//  Next-generation EX-stage ALU controller. Decodes alu_op/funct_code into the 3-bit ALU control.

---
 rtl/alu_md_controller.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_md_controller.sv
// EX-stage ALU control decoder with an iterative shift-add multiplier and HI/LO registers.
// Define ALU_CTRL_DIV_EN to add the restoring divider (DIV/DIVU); otherwise DIV/DIVU decode as illegal.
module alu_md_controller #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [2:0]       control_signal,
    output logic             illegal,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hilo_rdata
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
`ifdef ALU_CTRL_DIV_EN
        S_DIV  = 2'd2,
`endif
        S_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]      count_q, count_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               bad_op, is_mult, is_div, is_signed, is_mfhi, is_mflo, md_start;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_res;

    always_comb begin
        control_signal = 3'b010;
        bad_op    = 1'b0;
        is_mult   = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        is_mfhi   = 1'b0;
        is_mflo   = 1'b0;
        case (alu_op)
            2'b00: control_signal = 3'b010;
            2'b01: control_signal = 3'b110;
            2'b10: begin
                case (funct_code)
                    F_ADD:   control_signal = 3'b010;
                    F_SUB:   control_signal = 3'b110;
                    F_AND:   control_signal = 3'b000;
                    F_OR:    control_signal = 3'b001;
                    F_NOR:   control_signal = 3'b100;
                    F_SLT:   control_signal = 3'b111;
                    F_MULT:  begin is_mult = 1'b1; is_signed = 1'b1; end
                    F_MULTU: is_mult = 1'b1;
`ifdef ALU_CTRL_DIV_EN
                    F_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
                    F_DIVU:  is_div = 1'b1;
`endif
                    F_MFHI:  is_mfhi = 1'b1;
                    F_MFLO:  is_mflo = 1'b1;
                    default: bad_op = 1'b1;
                endcase
            end
            default: bad_op = 1'b1;
        endcase
    end

    assign illegal  = issue & bad_op;
    assign md_start = issue & (state_q == S_IDLE) & (is_mult | is_div);
    assign stall    = md_start | (state_q == S_MUL)
`ifdef ALU_CTRL_DIV_EN
                      | (state_q == S_DIV)
`endif
                      ;
    assign done     = (state_q == S_DONE);

    always_comb begin
        hilo_rdata = '0;
        if (issue && is_mfhi)      hilo_rdata = hi_q;
        else if (issue && is_mflo) hilo_rdata = lo_q;
    end

    // Signed ops run on magnitudes; the sign is re-applied when HI/LO are written.
    assign a_neg = is_signed & op_a[WIDTH-1];
    assign b_neg = is_signed & op_b[WIDTH-1];
    assign a_mag = a_neg ? -op_a : op_a;
    assign b_mag = b_neg ? -op_b : op_b;

    // Multiplier in the low half of prod_q, partial product accumulates in the high half.
    assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};
    assign mul_res  = neg_q ? -mul_next : mul_next;

`ifdef ALU_CTRL_DIV_EN
    logic               negr_q, negr_d, dz_q, dz_d;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   div_quo, div_rem;

    // Remainder in the high half; dividend bits shift out the top as quotient bits enter below.
    assign div_trial   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]} - {1'b0, opnd_q};
    assign div_next    = div_trial[WIDTH] ? {prod_q[2*WIDTH-2:0], 1'b0}
                                          : {div_trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    assign div_quo     = div_next[WIDTH-1:0];
    assign div_rem     = div_next[2*WIDTH-1:WIDTH];
    assign div_by_zero = (state_q == S_DONE) & dz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        prod_d  = prod_q;
        opnd_d  = opnd_q;
        count_d = count_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef ALU_CTRL_DIV_EN
        negr_d  = negr_q;
        dz_d    = dz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (md_start) begin
                    count_d = CW'(WIDTH);
                    neg_d   = a_neg ^ b_neg;
                    opnd_d  = is_mult ? a_mag : b_mag;
                    prod_d  = {{WIDTH{1'b0}}, (is_mult ? b_mag : a_mag)};
                    state_d = is_mult ? S_MUL : S_IDLE;
`ifdef ALU_CTRL_DIV_EN
                    negr_d  = a_neg;
                    dz_d    = is_div & (op_b == '0);
                    if (is_div) state_d = S_DIV;
`endif
                end
            end
            S_MUL: begin
                prod_d  = mul_next;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    {hi_d, lo_d} = mul_res;
                    state_d      = S_DONE;
                end
            end
`ifdef ALU_CTRL_DIV_EN
            S_DIV: begin
                prod_d  = div_next;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    // Divide by zero: the sign-fixed remainder already equals op_a.
                    lo_d    = dz_q ? '1 : (neg_q ? -div_quo : div_quo);
                    hi_d    = negr_q ? -div_rem : div_rem;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            prod_q  <= '0;
            opnd_q  <= '0;
            count_q <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef ALU_CTRL_DIV_EN
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
            opnd_q  <= opnd_d;
            count_q <= count_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef ALU_CTRL_DIV_EN
            negr_q  <= negr_d;
            dz_q    <= dz_d;
`endif
        end
    end
endmodule
